// File: rtl/sm83_pkg.sv
// Shared types and constants for the sm83 interrupt/halt scheduler.
// State codes D1..D5 equal their dispatch M-cycle number so disp_m can reuse them.
package sm83_pkg;

  typedef logic [2:0] irq_state_t;

  localparam irq_state_t RUN  = 3'd0;
  localparam irq_state_t D1   = 3'd1;
  localparam irq_state_t D2   = 3'd2;
  localparam irq_state_t D3   = 3'd3;
  localparam irq_state_t D4   = 3'd4;
  localparam irq_state_t D5   = 3'd5;
  localparam irq_state_t HALT = 3'd6;

  localparam logic [7:0] VEC_BASE   = 8'h40;
  localparam int         VEC_STRIDE = 8;

endpackage

// File: rtl/sm83_irq_prio.sv
// Combinational lowest-index priority encoder for the masked request lines.
module sm83_irq_prio #(
  parameter int NUM_IRQS = 8,
  parameter int IDX_W    = 3
) (
  input  logic [NUM_IRQS-1:0] req,
  output logic                any,
  output logic [IDX_W-1:0]    idx,
  output logic [NUM_IRQS-1:0] onehot
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    any    = |req;
    idx    = '0;
    onehot = '0;
    for (int i = NUM_IRQS - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sm83_irq_ctl.sv
// Interrupt and halt scheduler: IME with EI delay, fixed-priority arbitration,
// five-M-cycle dispatch sequencing and HALT park/wake.
module sm83_irq_ctl
  import sm83_pkg::*;
#(
  parameter int                   NUM_IRQS   = 8,
  parameter int                   WORD_SIZE  = 8,
  parameter logic [WORD_SIZE-1:0] VEC_BASE   = WORD_SIZE'(sm83_pkg::VEC_BASE),
  parameter int                   VEC_STRIDE = sm83_pkg::VEC_STRIDE
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 t4,
  input  logic                 op_done,
  input  logic                 ei,
  input  logic                 di,
  input  logic                 reti,
  input  logic                 halt,
  input  logic [NUM_IRQS-1:0]  irq,
  output logic                 take,
  output logic                 disp_active,
  output logic [2:0]           disp_m,
  output logic [WORD_SIZE-1:0] vec,
  output logic [NUM_IRQS-1:0]  iack,
  output logic                 halted,
  output logic                 ime
);

  localparam int IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

  irq_state_t state;
  irq_state_t state_nxt;

  logic                 ime_q;
  logic                 ime_pend;
  logic                 ime_next;
  logic [NUM_IRQS-1:0]  sel_oh;
  logic [WORD_SIZE-1:0] vec_q;

  logic                 prio_any;
  logic [IDX_W-1:0]     prio_idx;
  logic [NUM_IRQS-1:0]  prio_oh;
  logic [WORD_SIZE-1:0] vec_calc;

  sm83_irq_prio #(
    .NUM_IRQS (NUM_IRQS),
    .IDX_W    (IDX_W)
  ) u_prio (
    .req    (irq),
    .any    (prio_any),
    .idx    (prio_idx),
    .onehot (prio_oh)
  );

  assign vec_calc = VEC_BASE + WORD_SIZE'(VEC_STRIDE) * WORD_SIZE'(prio_idx);

  // The boundary check sees RETI's enable at once but not a pending EI.
  assign ime_next = !di && (reti || ime_q);

  always_comb begin
    take = 1'b0;
    if (n_reset && t4 && prio_any) begin
      if (state == RUN)
        take = op_done && ime_next;
      else if (state == HALT)
        take = ime_q;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (take)
          state_nxt = D1;
        else if (op_done && halt)
          state_nxt = HALT;
      end
      HALT: begin
        if (prio_any)
          state_nxt = ime_q ? D1 : RUN;
      end
      D1:      state_nxt = D2;
      D2:      state_nxt = D3;
      D3:      state_nxt = D4;
      D4:      state_nxt = D5;
      D5:      state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      state <= RUN;
    else if (t4)
      state <= state_nxt;
  end

  // Dispatch entry outranks any IME strobe decoded at the same boundary.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ime_q    <= 1'b0;
      ime_pend <= 1'b0;
    end else if (t4) begin
      if (take) begin
        ime_q    <= 1'b0;
        ime_pend <= 1'b0;
      end else if (state == RUN && op_done) begin
        if (di) begin
          ime_q    <= 1'b0;
          ime_pend <= 1'b0;
        end else begin
          if (reti || ime_pend)
            ime_q <= 1'b1;
          ime_pend <= ei;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sel_oh <= '0;
      vec_q  <= '0;
    end else if (t4 && state == D3) begin
      sel_oh <= prio_oh;
      vec_q  <= prio_any ? vec_calc : '0;
    end
  end

  assign disp_active = (state >= D1) && (state <= D5);
  assign disp_m      = disp_active ? state : 3'd0;
  assign halted      = (state == HALT);
  assign iack        = (state == D5 && t4) ? sel_oh : '0;
  assign vec         = vec_q;
  assign ime         = ime_q;

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Directed bench for sm83_irq_ctl: EI delay, priority, withdraw, HALT, conflicts, reset.
module tb_sm83_irq_ctl;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       t4, op_done, ei, di, reti, halt;
  logic [7:0] irq;
  logic       take, disp_active, halted, ime;
  logic [2:0] disp_m;
  logic [7:0] vec, iack;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sm83_irq_ctl dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .t4          (t4),
    .op_done     (op_done),
    .ei          (ei),
    .di          (di),
    .reti        (reti),
    .halt        (halt),
    .irq         (irq),
    .take        (take),
    .disp_active (disp_active),
    .disp_m      (disp_m),
    .vec         (vec),
    .iack        (iack),
    .halted      (halted),
    .ime         (ime)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_strobes();
    t4 = 1'b0; op_done = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0; halt = 1'b0;
  endtask

  // One M-cycle: three non-t4 clocks, then the t4 clock carrying the strobes.
  task automatic apply_stimulus(input logic od, input logic e, input logic d,
                                input logic r, input logic h);
    repeat (3) begin
      @(negedge clk);
      clear_strobes();
    end
    @(negedge clk);
    t4 = 1'b1; op_done = od; ei = e; di = d; reti = r; halt = h;
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    clear_strobes();
    #1;
  endtask

  task automatic run_dispatch(input string tag, input logic [7:0] irq_d2,
                              input logic [7:0] exp_vec, input logic [7:0] exp_iack);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output({tag, " d1 disp_m"}, disp_m, 1);
    check_output({tag, " d1 active"}, disp_active, 1);
    check_output({tag, " d1 ime"}, ime, 0);
    check_output({tag, " d1 halted"}, halted, 0);
    irq = irq_d2;
    apply_stimulus(0, 0, 0, 0, 0);
    check_output({tag, " d2 disp_m"}, disp_m, 2);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output({tag, " d3 disp_m"}, disp_m, 3);
    check_output({tag, " d3 iack"}, iack, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output({tag, " d4 disp_m"}, disp_m, 4);
    check_output({tag, " d4 vec"}, vec, exp_vec);
    check_output({tag, " d4 iack"}, iack, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output({tag, " d5 disp_m"}, disp_m, 5);
    check_output({tag, " d5 vec"}, vec, exp_vec);
    check_output({tag, " d5 iack"}, iack, exp_iack);
    settle();
    check_output({tag, " post iack"}, iack, 0);
    check_output({tag, " post active"}, disp_active, 0);
    check_output({tag, " post disp_m"}, disp_m, 0);
    check_output({tag, " post halted"}, halted, 0);
    check_output({tag, " post ime"}, ime, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " take"}, take, 0);
    check_output({tag, " active"}, disp_active, 0);
    check_output({tag, " disp_m"}, disp_m, 0);
    check_output({tag, " vec"}, vec, 0);
    check_output({tag, " iack"}, iack, 0);
    check_output({tag, " halted"}, halted, 0);
    check_output({tag, " ime"}, ime, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_reset = 1'b0;
    irq     = 8'h00;
    clear_strobes();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    n_reset = 1'b1;

    // EI delay: one full instruction must follow EI before dispatch
    irq = 8'h01;
    apply_stimulus(1, 1, 0, 0, 0);
    check_output("ei boundary take", take, 0);
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("ei next take", take, 0);
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("ei after take", take, 1);
    check_output("ei after ime", ime, 1);
    run_dispatch("ei", 8'h01, 8'h40, 8'h01);

    // Priority through RETI's immediate enable
    irq = 8'h14;
    apply_stimulus(1, 0, 0, 1, 0);
    check_output("prio take", take, 1);
    run_dispatch("prio", 8'h14, 8'h50, 8'h04);

    // Request withdrawn during D2
    irq = 8'h02;
    apply_stimulus(1, 0, 0, 1, 0);
    check_output("withdraw take", take, 1);
    run_dispatch("withdraw", 8'h00, 8'h00, 8'h00);
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("withdraw run take", take, 0);

    // HALT wake with IME clear
    irq = 8'h00;
    apply_stimulus(1, 0, 0, 0, 1);
    check_output("halt0 take", take, 0);
    settle();
    check_output("halt0 halted", halted, 1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("halt0 idle halted", halted, 1);
    irq = 8'h08;
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("halt0 wake take", take, 0);
    settle();
    check_output("halt0 woke halted", halted, 0);
    check_output("halt0 woke active", disp_active, 0);

    // HALT wake with IME set
    irq = 8'h00;
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0);
    settle();
    check_output("halt1 ime", ime, 1);
    apply_stimulus(1, 0, 0, 0, 1);
    check_output("halt1 enter take", take, 0);
    settle();
    check_output("halt1 halted", halted, 1);
    irq = 8'h08;
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("halt1 wake take", take, 1);
    run_dispatch("halt1", 8'h08, 8'h58, 8'h08);

    // HALT and a pending request at one boundary: dispatch wins
    irq = 8'h01;
    apply_stimulus(1, 0, 0, 1, 1);
    check_output("halt+irq take", take, 1);
    run_dispatch("halt+irq", 8'h01, 8'h40, 8'h01);

    // DI beats EI in the same strobe, leaving nothing pending
    irq = 8'h00;
    apply_stimulus(1, 1, 0, 0, 0);
    apply_stimulus(1, 1, 1, 0, 0);
    irq = 8'h01;
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("di+ei take1", take, 0);
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("di+ei take2", take, 0);
    settle();
    check_output("di+ei ime", ime, 0);

    // Reset asserted in the middle of D4
    irq = 8'h02;
    apply_stimulus(1, 0, 0, 1, 0);
    check_output("rst take", take, 1);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0);
    settle();
    check_output("rst d4 disp_m", disp_m, 4);
    n_reset = 1'b0;
    #1;
    check_all_zero("rst async");
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    check_output("rst release active", disp_active, 0);
    check_output("rst release ime", ime, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("rst run iack", iack, 0);
    check_output("rst run disp_m", disp_m, 0);
    apply_stimulus(1, 0, 0, 0, 0);
    check_output("rst boundary take", take, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
